adat_check: RTL
===============

// Module: adat_check
// PURPOSE
//  Receive-side counterpart of the serial test-data generator. Samples the serial
//  bit on each data_change strobe, hunts for alignment to the fixed 28-bit test
//  pattern, verifies it, and once locked outputs SYM_W-bit symbols for the QAM
//  mapper path. It also counts bit errors against the expected pattern.
// PARAMETERS
//  PATTERN_W  28           pattern length in bits; must be a multiple of SYM_W
//  PATTERN    28'h6CC1555  expected pattern; bits are sent MSB first, rotating left
//  SYM_W      4            bits per output symbol (16-QAM)
//  LOSS_THR   4            errors within one pattern period that force re-hunt
//  ERR_W      16           width of the bit-error counter
// PORTS
//  clock        in   1      system clock; all logic on posedge
//  reset        in   1      asynchronous, active-low reset
//  adat_be      in   1      serial data bit
//  data_change  in   1      new-bit strobe; the bit is sampled on its rising edge only
//  clr_err      in   1      synchronous clear of bit_err_cnt
//  symbol       out  SYM_W  last assembled symbol, MSB = first received bit
//  symbol_valid out  1      one-cycle pulse when symbol is updated
//  locked       out  1      high in LOCKED state
//  err_pulse    out  1      one-cycle pulse per mismatched bit in LOCKED
//  bit_err_cnt  out  ERR_W  accumulated bit errors in LOCKED
// BEHAVIOUR
//  - Reset (reset=0, async): state=HUNT; window, pointer, period error count and
//    bit_err_cnt=0; symbol=0; symbol_valid, locked and err_pulse=0. Reset mid-stream
//    clears everything immediately.
//  - Edge detection: register data_change. The sample edge E is the clock edge at
//    which data_change=1 and the registered copy is 0. A strobe held high for N cycles
//    yields exactly one sample.
//  - At E, shift adat_be into the LSB of a PATTERN_W-bit window. All outputs are
//    registered at E and are visible in the cycle after E (1-cycle latency).
//  - FSM:
//    HUNT:   if the window (including the new bit) == PATTERN -> CHECK;
//            set pointer=PATTERN_W-1, so the next expected bit is PATTERN[PATTERN_W-1].
//    CHECK:  compare each bit with PATTERN[pointer]. Any mismatch -> HUNT.
//            After PATTERN_W consecutive matches -> LOCKED. No symbols, no error counting.
//    LOCKED: compare each bit; on mismatch, pulse err_pulse, increment bit_err_cnt and
//            increment the period error count. If the period count reaches LOSS_THR
//            -> HUNT, locked drops and the window is cleared.
//  - Pointer decrements per bit and wraps from 0 to PATTERN_W-1. The period error
//    count clears at the wrap.
//  - Symbols: in LOCKED, shift received bits (not expected bits) into a SYM_W assembler.
//    When the consumed pointer index mod SYM_W == 0, load symbol and pulse symbol_valid.
//    This aligns symbols to the pattern start. A partial symbol is discarded on leaving
//    LOCKED.
//  - clr_err and an error at the same edge: the clear applies first, so bit_err_cnt=1.
//  - The bit that causes LOCKED -> HUNT is still counted and still pulses err_pulse.
// CONFIGURATION
//  ADAT_CHECK_SAT_EN defined:     bit_err_cnt saturates at all-ones.
//  ADAT_CHECK_SAT_EN not defined: bit_err_cnt wraps modulo 2**ERR_W.
// STRUCTURE
//  Shared package qam_pkg holds:
//  - ADAT_PATTERN and ADAT_PATTERN_W, shared with the generator;
//  - SYM_W;
//  - the state encoding HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2.
//  One sub-module, adat_edge_det (registered rise detector for data_change). The FSM,
//  compare logic and assembler stay in adat_check.
// TESTING
//  1 Clean stream, pattern sent from its MSB -> CHECK after 28 bits, LOCKED after 56.
//    Symbols then repeat 6,C,C,1,5,5,5; bit_err_cnt=0.
//  2 Stream started at a 5-bit offset -> HUNT until the first aligned window (bit 28+23).
//    Then CHECK, then LOCKED; the first symbol is 6.
//  3 One flipped bit in LOCKED (first bit of the symbol 1) -> one err_pulse,
//    bit_err_cnt=1, symbol 9 emitted, locked stays 1.
//  4 Four flips within one period -> on the 4th: err_pulse, bit_err_cnt=4, locked=0
//    the next cycle, no more symbol_valid until relock.
//  5 One flip during CHECK -> HUNT, no err_pulse. data_change held high 10 cycles
//    -> exactly one sample.
//  6 ERR_W=4, 20 errors spread at 1 per period -> bit_err_cnt=15 with ADAT_CHECK_SAT_EN,
//    4 without. clr_err with a simultaneous error -> 1. reset pulsed low mid-symbol
//    -> all outputs 0 at once.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared definitions for the serial test-data generator / checker pair and the QAM path.
package qam_pkg;

  localparam int              ADAT_PATTERN_W = 28;
  localparam logic [27:0]     ADAT_PATTERN   = 28'h6CC1555;
  localparam int              SYM_W          = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } adat_state_t;

endpackage

// File: rtl/adat_check_if.sv
// Serial test-data link between the stream source and the checker.
// master: drives the serial bit, strobe and error clear; slave: the checker.
interface adat_check_if #(
  parameter int SYM_W = 4,
  parameter int ERR_W = 16
);
  logic             adat_be;
  logic             data_change;
  logic             clr_err;
  logic [SYM_W-1:0] symbol;
  logic             symbol_valid;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] bit_err_cnt;

  modport master (
    output adat_be, data_change, clr_err,
    input  symbol, symbol_valid, locked, err_pulse, bit_err_cnt
  );

  modport slave (
    input  adat_be, data_change, clr_err,
    output symbol, symbol_valid, locked, err_pulse, bit_err_cnt
  );
endinterface

// File: rtl/adat_edge_det.sv
// Rising-edge detector for the new-bit strobe; a strobe held high yields one pulse.
module adat_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic rise
);
  logic strobe_q;

  // Remember last cycle's strobe level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) strobe_q <= 1'b0;
    else        strobe_q <= strobe;
  end

  assign rise = strobe & ~strobe_q;
endmodule

// File: rtl/adat_check.sv
// Serial test-pattern checker: hunts for alignment to the fixed pattern, verifies
// one full period, then emits pattern-aligned symbols and counts bit errors.
//
// state  | meaning
// HUNT   | sliding the window, waiting for it to equal the pattern
// CHECK  | aligned once, verifying one full period without error
// LOCKED | verified; emitting symbols and counting bit errors
//
// Build option: define ADAT_CHECK_SAT_EN to make bit_err_cnt saturate at all-ones;
// otherwise it wraps.
module adat_check
  import qam_pkg::*;
#(
  parameter int                    PATTERN_W = ADAT_PATTERN_W,
  parameter logic [PATTERN_W-1:0]  PATTERN   = ADAT_PATTERN,
  parameter int                    SYM_W     = qam_pkg::SYM_W,
  parameter int                    LOSS_THR  = 4,
  parameter int                    ERR_W     = 16
) (
  input  logic         clock,
  input  logic         reset,
  adat_check_if.slave  bus
);
  localparam int PTR_W = $clog2(PATTERN_W);
  localparam int PER_W = $clog2(LOSS_THR + 1);

  adat_state_t          state;
  logic [PATTERN_W-1:0] window, window_next;
  logic [PTR_W-1:0]     ptr, ptr_next;
  logic [PER_W-1:0]     per_err;
  logic [SYM_W-1:0]     asm_q, sym_next, symbol_q;
  logic                 symbol_valid_q, locked_q, err_pulse_q;
  logic [ERR_W-1:0]     err_cnt, err_base;
  logic                 sample, bit_in, mismatch, at_wrap, sym_boundary;

  adat_edge_det u_edge (
    .clock  (clock),
    .reset  (reset),
    .strobe (bus.data_change),
    .rise   (sample)
  );

  function automatic logic [ERR_W-1:0] cnt_inc(input logic [ERR_W-1:0] v);
`ifdef ADAT_CHECK_SAT_EN
    return (v == '1) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  // Next window, expected-bit compare, pointer wrap and symbol boundary
  always_comb begin
    bit_in       = bus.adat_be;
    window_next  = {window[PATTERN_W-2:0], bit_in};
    mismatch     = (bit_in != PATTERN[ptr]);
    at_wrap      = (ptr == '0);
    ptr_next     = at_wrap ? PTR_W'(PATTERN_W - 1) : ptr - 1'b1;
    sym_next     = {asm_q[SYM_W-2:0], bit_in};
    sym_boundary = ((int'(ptr) % SYM_W) == 0);
    // A clear in the same cycle as an error is applied before the increment
    err_base     = bus.clr_err ? '0 : err_cnt;
  end

  // Alignment FSM, symbol assembler and error counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= HUNT;
      window         <= '0;
      ptr            <= '0;
      per_err        <= '0;
      asm_q          <= '0;
      symbol_q       <= '0;
      symbol_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_cnt        <= '0;
    end else begin
      symbol_valid_q <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_cnt        <= err_base;
      if (sample) begin
        window <= window_next;
        case (state)
          HUNT: begin
            if (window_next == PATTERN) begin
              state <= CHECK;
              ptr   <= PTR_W'(PATTERN_W - 1);
            end
          end
          CHECK: begin
            if (mismatch) begin
              state <= HUNT;
            end else begin
              ptr <= ptr_next;
              // Last pattern bit verified: a full clean period has been seen
              if (at_wrap) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                per_err  <= '0;
              end
            end
          end
          LOCKED: begin
            ptr   <= ptr_next;
            asm_q <= sym_next;
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              err_cnt     <= cnt_inc(err_base);
            end
            if (mismatch && (per_err == PER_W'(LOSS_THR - 1))) begin
              state    <= HUNT;
              locked_q <= 1'b0;
              window   <= '0;
              asm_q    <= '0;
              per_err  <= '0;
            end else begin
              if (sym_boundary) begin
                symbol_q       <= sym_next;
                symbol_valid_q <= 1'b1;
              end
              if (at_wrap)       per_err <= '0;
              else if (mismatch) per_err <= per_err + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.symbol       = symbol_q;
  assign bus.symbol_valid = symbol_valid_q;
  assign bus.locked       = locked_q;
  assign bus.err_pulse    = err_pulse_q;
  assign bus.bit_err_cnt  = err_cnt;
endmodule
